// File: rtl/idct4_pipe_if.sv
// idct4_pipe_if: beat-in/beat-out handshake and data bundle for the 4-point IDCT pipe
interface idct4_pipe_if #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16
);
  logic in_valid, in_ready, in_pass;
  logic signed [IN_W-1:0] s0, s1, s2, s3;
  logic out_valid, out_ready, out_sat;
  logic signed [OUT_W-1:0] d0, d1, d2, d3;
  modport master (
    output in_valid, in_pass, s0, s1, s2, s3, out_ready,
    input in_ready, out_valid, out_sat, d0, d1, d2, d3
  );
  modport slave (
    input in_valid, in_pass, s0, s1, s2, s3, out_ready,
    output in_ready, out_valid, out_sat, d0, d1, d2, d3
  );
endinterface

// File: rtl/idct4_pipe.sv
// idct4_pipe: 3-stage 4-point inverse-DCT butterfly with per-beat pass shift and saturation
module idct4_pipe #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT0 = 7,
  parameter int SHIFT1 = 12
) (
  input logic clk,
  input logic reset,
  idct4_pipe_if.slave io
);
  localparam int ACC_W = IN_W + 9;
  localparam logic signed [ACC_W-1:0] C64 = ACC_W'(64);
  localparam logic signed [ACC_W-1:0] C83 = ACC_W'(83);
  localparam logic signed [ACC_W-1:0] C36 = ACC_W'(36);
  localparam logic signed [ACC_W-1:0] RND0 = ACC_W'(1) << (SHIFT0 - 1);
  localparam logic signed [ACC_W-1:0] RND1 = ACC_W'(1) << (SHIFT1 - 1);
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

  logic en;
  logic v1, pass1, v2, pass2;
  logic signed [ACC_W-1:0] p0, p2, p1a, p1b, p3a, p3b;
  logic signed [ACC_W-1:0] e0, e1, o0, o1;
  logic signed [ACC_W-1:0] r [4];
  logic [OUT_W:0] q [4];

  assign en = !io.out_valid | io.out_ready;
  assign io.in_ready = en;

  function automatic logic [OUT_W:0] scale(input logic signed [ACC_W-1:0] x, input logic pass);
    logic signed [ACC_W-1:0] t;
    t = pass ? (x + RND1) >>> SHIFT1 : (x + RND0) >>> SHIFT0;
    return t > MAXV ? {1'b1, MAXV[OUT_W-1:0]} : t < MINV ? {1'b1, MINV[OUT_W-1:0]} : {1'b0, t[OUT_W-1:0]};
  endfunction

  // final butterfly, rounding shift and clipping for the beat in stage 2
  always_comb begin
    r[0] = e0 + o0;
    r[1] = e1 + o1;
    r[2] = e1 - o1;
    r[3] = e0 - o0;
    for (int k = 0; k < 4; k++) q[k] = scale(r[k], pass2);
  end

  // pipeline registers; every stage advances together under the global stall
  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      io.out_valid <= 1'b0;
      io.out_sat <= 1'b0;
      io.d0 <= '0;
      io.d1 <= '0;
      io.d2 <= '0;
      io.d3 <= '0;
    end else if (en) begin
      v1 <= io.in_valid;
      pass1 <= io.in_pass;
      p0 <= C64 * ACC_W'(io.s0);
      p2 <= C64 * ACC_W'(io.s2);
      p1a <= C83 * ACC_W'(io.s1);
      p1b <= C36 * ACC_W'(io.s1);
      p3a <= C83 * ACC_W'(io.s3);
      p3b <= C36 * ACC_W'(io.s3);
      v2 <= v1;
      pass2 <= pass1;
      e0 <= p0 + p2;
      e1 <= p0 - p2;
      o0 <= p1a + p3b;
      o1 <= p1b - p3a;
      io.out_valid <= v2;
      io.d0 <= q[0][OUT_W-1:0];
      io.d1 <= q[1][OUT_W-1:0];
      io.d2 <= q[2][OUT_W-1:0];
      io.d3 <= q[3][OUT_W-1:0];
      io.out_sat <= v2 & (q[0][OUT_W] | q[1][OUT_W] | q[2][OUT_W] | q[3][OUT_W]);
    end
  end
endmodule
